// File: rtl/req_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// req_pkg : shared widths and FSM state type for the req_arb slice | rev 1.0
// ---------------------------------------------------------------------------
package req_pkg;
  localparam int LEN_W  = 3;
  localparam int MASK_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/req_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// req_rr_arb : two-way fixed-priority / round-robin grant decision | rev 1.0
// ---------------------------------------------------------------------------
module req_rr_arb
  import req_pkg::*;
#(
  parameter int unsigned M1_PRIO = 1
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_m1,
  output logic o_gnt_m1
);

  // On a tie, round-robin hands the grant to whichever master did not finish last.
  always_comb begin
    o_gnt_m1 = i_req1;
    if (i_req0 && i_req1) begin
      o_gnt_m1 = (M1_PRIO != 0) ? 1'b1 : ~i_last_m1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/req_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// req_arb : two-master (CPU / VGA fetch) arbiter in front of one SDRAM port | rev 1.0
// ---------------------------------------------------------------------------
module req_arb
  import req_pkg::*;
#(
  parameter int unsigned M1_PRIO = 1,
  parameter int unsigned CNT_W   = 3
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [LEN_W-1:0]  m0_req_len,
  input  logic [MASK_W-1:0] m0_req_mask,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_write_valid,
  input  logic [DATA_W-1:0] m0_write_data,
  output logic              m0_read_valid,
  output logic [DATA_W-1:0] m0_read_data,
  input  logic              m0_read_ack,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [LEN_W-1:0]  m1_req_len,
  input  logic [MASK_W-1:0] m1_req_mask,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_write_valid,
  input  logic [DATA_W-1:0] m1_write_data,
  output logic              m1_read_valid,
  output logic [DATA_W-1:0] m1_read_data,
  input  logic              m1_read_ack,
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic              s_req_we,
  output logic [LEN_W-1:0]  s_req_len,
  output logic [MASK_W-1:0] s_req_mask,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic              s_write_valid,
  output logic [DATA_W-1:0] s_write_data,
  input  logic              s_read_valid,
  input  logic [DATA_W-1:0] s_read_data,
  output logic              s_read_ack,
  output logic              busy
);

  state_t             r_state;
  logic               r_gnt;
  logic               r_last;
  logic               r_we;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_gnt_next;
  logic               w_in_req;
  logic               w_in_wdata;
  logic               w_in_rdata;
  logic               w_mg_req_valid;
  logic               w_mg_we;
  logic [LEN_W-1:0]   w_mg_len;
  logic [MASK_W-1:0]  w_mg_mask;
  logic [ADDR_W-1:0]  w_mg_addr;
  logic               w_mg_write_valid;
  logic [DATA_W-1:0]  w_mg_write_data;
  logic               w_mg_read_ack;
  logic               w_beat;
  logic               w_last_beat;

  req_rr_arb #(
    .M1_PRIO (M1_PRIO)
  ) u_rr_arb (
    .i_req0    (m0_req_valid),
    .i_req1    (m1_req_valid),
    .i_last_m1 (r_last),
    .o_gnt_m1  (w_gnt_next)
  );

  assign w_in_req   = (r_state == ST_REQ);
  assign w_in_wdata = (r_state == ST_WDATA);
  assign w_in_rdata = (r_state == ST_RDATA);

  assign w_mg_req_valid   = r_gnt ? m1_req_valid   : m0_req_valid;
  assign w_mg_we          = r_gnt ? m1_req_we      : m0_req_we;
  assign w_mg_len         = r_gnt ? m1_req_len     : m0_req_len;
  assign w_mg_mask        = r_gnt ? m1_req_mask    : m0_req_mask;
  assign w_mg_addr        = r_gnt ? m1_req_addr    : m0_req_addr;
  assign w_mg_write_valid = r_gnt ? m1_write_valid : m0_write_valid;
  assign w_mg_write_data  = r_gnt ? m1_write_data  : m0_write_data;
  assign w_mg_read_ack    = r_gnt ? m1_read_ack    : m0_read_ack;

  // Every slave-facing signal is gated by state so reset and IDLE drive all zeros.
  assign s_req_valid   = w_in_req & w_mg_req_valid;
  assign s_req_we      = w_in_req & w_mg_we;
  assign s_req_len     = w_in_req ? w_mg_len  : '0;
  assign s_req_mask    = w_in_req ? w_mg_mask : '0;
  assign s_req_addr    = w_in_req ? w_mg_addr : '0;
  assign m0_req_ready  = w_in_req & ~r_gnt & s_req_ready;
  assign m1_req_ready  = w_in_req &  r_gnt & s_req_ready;

  assign s_write_valid = w_in_wdata & r_we & w_mg_write_valid;
  assign s_write_data  = w_in_wdata ? w_mg_write_data : '0;

  assign s_read_ack    = w_in_rdata & w_mg_read_ack;
  assign m0_read_valid = w_in_rdata & ~r_gnt & s_read_valid;
  assign m1_read_valid = w_in_rdata &  r_gnt & s_read_valid;
  assign m0_read_data  = w_in_rdata ? s_read_data : '0;
  assign m1_read_data  = w_in_rdata ? s_read_data : '0;

  assign busy        = (r_state != ST_IDLE);
  assign w_beat      = s_write_valid | (s_read_valid & s_read_ack);
  assign w_last_beat = (r_cnt == CNT_W'(r_len));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_req_valid || m1_req_valid) begin
            r_gnt   <= w_gnt_next;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!w_mg_req_valid) begin
            r_state <= ST_IDLE;
          end else if (s_req_ready) begin
            r_we    <= w_mg_we;
            r_len   <= w_mg_len;
            r_cnt   <= '0;
            r_state <= w_mg_we ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA, ST_RDATA: begin
          if (w_beat) begin
            if (w_last_beat) begin
              r_state <= ST_IDLE;
              r_last  <= r_gnt;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_req_arb.sv
`default_nettype none
// Bench for req_arb: default instance (m1 priority) plus a round-robin instance on shared inputs.
module tb_req_arb;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        m0_req_valid, m0_req_we, m0_write_valid, m0_read_ack;
  logic [2:0]  m0_req_len;
  logic [3:0]  m0_req_mask;
  logic [31:0] m0_req_addr, m0_write_data;
  logic        m1_req_valid, m1_req_we, m1_write_valid, m1_read_ack;
  logic [2:0]  m1_req_len;
  logic [3:0]  m1_req_mask;
  logic [31:0] m1_req_addr, m1_write_data;
  logic        s_req_ready, s_read_valid;
  logic [31:0] s_read_data;

  logic        m0_req_ready, m0_read_valid, m1_req_ready, m1_read_valid;
  logic [31:0] m0_read_data, m1_read_data;
  logic        s_req_valid, s_req_we, s_write_valid, s_read_ack, busy;
  logic [2:0]  s_req_len;
  logic [3:0]  s_req_mask;
  logic [31:0] s_req_addr, s_write_data;

  logic        rr_m0_req_ready, rr_m0_read_valid, rr_m1_req_ready, rr_m1_read_valid;
  logic [31:0] rr_m0_read_data, rr_m1_read_data;
  logic        rr_s_req_valid, rr_s_req_we, rr_s_write_valid, rr_s_read_ack, rr_busy;
  logic [2:0]  rr_s_req_len;
  logic [3:0]  rr_s_req_mask;
  logic [31:0] rr_s_req_addr, rr_s_write_data;

  int total = 0;
  int bad   = 0;
  bit rr_last = 1'b1;   // model of which master finished last (round-robin instance)

  req_arb u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_len(m0_req_len), .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr),
    .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
    .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_len(m1_req_len), .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr),
    .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
    .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
    .s_req_len(s_req_len), .s_req_mask(s_req_mask), .s_req_addr(s_req_addr),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(s_read_ack),
    .busy(busy)
  );

  req_arb #(.M1_PRIO(0)) u_rr (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_req_valid(m0_req_valid), .m0_req_ready(rr_m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_len(m0_req_len), .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr),
    .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
    .m0_read_valid(rr_m0_read_valid), .m0_read_data(rr_m0_read_data), .m0_read_ack(m0_read_ack),
    .m1_req_valid(m1_req_valid), .m1_req_ready(rr_m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_len(m1_req_len), .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr),
    .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
    .m1_read_valid(rr_m1_read_valid), .m1_read_data(rr_m1_read_data), .m1_read_ack(m1_read_ack),
    .s_req_valid(rr_s_req_valid), .s_req_ready(s_req_ready), .s_req_we(rr_s_req_we),
    .s_req_len(rr_s_req_len), .s_req_mask(rr_s_req_mask), .s_req_addr(rr_s_req_addr),
    .s_write_valid(rr_s_write_valid), .s_write_data(rr_s_write_data),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(rr_s_read_ack),
    .busy(rr_busy)
  );

  task automatic clear_in();
    m0_req_valid = 0; m0_req_we = 0; m0_req_len = '0; m0_req_mask = '0; m0_req_addr = '0;
    m0_write_valid = 0; m0_write_data = '0; m0_read_ack = 0;
    m1_req_valid = 0; m1_req_we = 0; m1_req_len = '0; m1_req_mask = '0; m1_req_addr = '0;
    m1_write_valid = 0; m1_write_data = '0; m1_read_ack = 0;
    s_req_ready = 0; s_read_valid = 0; s_read_data = '0;
  endtask

  task automatic set_req(input bit m, input bit v, input bit we, input logic [2:0] len,
                         input logic [3:0] mask, input logic [31:0] addr);
    if (m) begin
      m1_req_valid = v; m1_req_we = we; m1_req_len = len; m1_req_mask = mask; m1_req_addr = addr;
    end else begin
      m0_req_valid = v; m0_req_we = we; m0_req_len = len; m0_req_mask = mask; m0_req_addr = addr;
    end
  endtask

  task automatic test_reset();
    clear_in();
    m0_req_valid = 1; m0_req_addr = 32'h1234_5678; m1_write_valid = 1;
    s_read_valid = 1; s_read_data = $urandom; m0_read_ack = 1; s_req_ready = 1;
    rstn_i = 0;
    #2;
    total++; if ({s_req_valid, s_req_addr, s_req_mask, s_req_len, s_req_we} !== 41'd0) begin bad++; $display("FAIL rst_sreq got=%0h want=0", {s_req_valid, s_req_addr}); end
    total++; if ({m0_req_ready, m1_req_ready, m0_read_valid, m1_read_valid, s_read_ack, s_write_valid} !== 6'd0) begin bad++; $display("FAIL rst_hs got=%b want=000000", {m0_req_ready, m1_req_ready, m0_read_valid, m1_read_valid, s_read_ack, s_write_valid}); end
    total++; if ({busy, rr_busy} !== 2'b00) begin bad++; $display("FAIL rst_busy got=%b want=00", {busy, rr_busy}); end
    total++; if (m0_read_data !== 32'd0 || s_write_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%0h/%0h want=0/0", m0_read_data, s_write_data); end
    @(negedge clk_i);
    clear_in();
    rstn_i = 1; rr_last = 1'b1;
    @(negedge clk_i); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%0b want=0", busy); end
  endtask

  // Drives one complete transaction from master m with random stalls; checks routing and beat count.
  task automatic xfer(input bit m, input bit we, input logic [2:0] len, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] d0);
    int left, cyc;
    bit acc, first, wv, ack;
    logic [31:0] wd;
    @(negedge clk_i);
    clear_in();
    set_req(m, 1'b1, we, len, mask, addr);
    #1;
    total++; if ({s_req_valid, busy} !== 2'b00) begin bad++; $display("FAIL xfer_idle got=%b want=00", {s_req_valid, busy}); end
    acc = 0; cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk_i); cyc++;
      s_req_ready = ($urandom_range(3) != 0);
      #1;
      total++; if ({s_req_valid, s_req_we, s_req_len, s_req_mask, s_req_addr} !== {1'b1, we, len, mask, addr})
        begin bad++; $display("FAIL xfer_sreq got=%0h want=%0h", {s_req_valid, s_req_we, s_req_len, s_req_mask, s_req_addr}, {1'b1, we, len, mask, addr}); end
      total++; if ({m1_req_ready, m0_req_ready} !== (m ? {s_req_ready, 1'b0} : {1'b0, s_req_ready}))
        begin bad++; $display("FAIL xfer_ready got=%b want_m=%0d rdy=%0b", {m1_req_ready, m0_req_ready}, m, s_req_ready); end
      acc = s_req_ready;
    end
    if (!acc) begin total++; bad++; $display("FAIL xfer_accept got=timeout want=accept"); end
    left = int'(len) + 1; cyc = 0; first = 1;
    while (left > 0 && cyc < 200) begin
      @(negedge clk_i); cyc++;
      set_req(m, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
      s_req_ready = 0;
      m0_write_valid = 1'($urandom_range(1)); m1_write_valid = 1'($urandom_range(1));
      m0_write_data = $urandom; m1_write_data = $urandom;
      m0_read_ack = 1'($urandom_range(1)); m1_read_ack = 1'($urandom_range(1));
      s_read_valid = 1'($urandom_range(1)); s_read_data = $urandom;
      if (first) begin
        if (m) m1_write_data = d0; else m0_write_data = d0;
        s_read_data = d0;
      end
      #1;
      if (we) begin
        wv = m ? m1_write_valid : m0_write_valid;
        wd = m ? m1_write_data : m0_write_data;
        total++; if (s_write_valid !== wv) begin bad++; $display("FAIL wr_valid got=%0b want=%0b", s_write_valid, wv); end
        if (wv) begin
          total++; if (s_write_data !== wd) begin bad++; $display("FAIL wr_data got=%h want=%h", s_write_data, wd); end
          left--; first = 0;
        end
        total++; if ({s_read_ack, m0_read_valid, m1_read_valid} !== 3'b000) begin bad++; $display("FAIL wr_rdgate got=%b want=000", {s_read_ack, m0_read_valid, m1_read_valid}); end
      end else begin
        ack = m ? m1_read_ack : m0_read_ack;
        total++; if ({m1_read_valid, m0_read_valid} !== (m ? {s_read_valid, 1'b0} : {1'b0, s_read_valid}))
          begin bad++; $display("FAIL rd_valid got=%b want_m=%0d sv=%0b", {m1_read_valid, m0_read_valid}, m, s_read_valid); end
        total++; if (s_read_ack !== ack) begin bad++; $display("FAIL rd_ack got=%0b want=%0b", s_read_ack, ack); end
        total++; if (m0_read_data !== s_read_data || m1_read_data !== s_read_data) begin bad++; $display("FAIL rd_data got=%h/%h want=%h", m0_read_data, m1_read_data, s_read_data); end
        total++; if (s_write_valid !== 1'b0) begin bad++; $display("FAIL rd_wrgate got=%0b want=0", s_write_valid); end
        if (s_read_valid && ack) begin left--; first = 0; end
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL xfer_busy got=%0b want=1 left=%0d", busy, left); end
    end
    if (left > 0) begin total++; bad++; $display("FAIL xfer_beats got=timeout want=%0d more beats", left); end
    @(negedge clk_i);
    clear_in();
    #1;
    total++; if ({busy, rr_busy, s_req_valid, s_write_valid} !== 4'b0000) begin bad++; $display("FAIL xfer_done got=%b want=0000", {busy, rr_busy, s_req_valid, s_write_valid}); end
    rr_last = m;
  endtask

  task automatic test_contention();
    bit exp_rr;
    logic [31:0] a0, a1;
    a0 = 32'h0000_1000; a1 = 32'h0000_2000;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk_i);
      clear_in();
      set_req(1'b0, 1'b1, 1'b0, 3'd0, 4'hF, a0);
      set_req(1'b1, 1'b1, 1'b0, 3'd0, 4'hF, a1);
      s_req_ready = 1;
      #1;
      total++; if ({busy, rr_busy} !== 2'b00) begin bad++; $display("FAIL ct_gap r=%0d got=%b want=00", r, {busy, rr_busy}); end
      exp_rr = ~rr_last;
      @(negedge clk_i); #1;
      total++; if ({m1_req_ready, m0_req_ready, s_req_addr} !== {2'b10, a1}) begin bad++; $display("FAIL ct_prio r=%0d got=%b/%h want=10/%h", r, {m1_req_ready, m0_req_ready}, s_req_addr, a1); end
      total++; if ({rr_m1_req_ready, rr_m0_req_ready, rr_s_req_addr} !== {exp_rr, ~exp_rr, exp_rr ? a1 : a0})
        begin bad++; $display("FAIL ct_rr r=%0d got=%b/%h want_m=%0d", r, {rr_m1_req_ready, rr_m0_req_ready}, rr_s_req_addr, exp_rr); end
      @(negedge clk_i);
      s_req_ready = 0; s_read_valid = 1; s_read_data = $urandom; m0_read_ack = 1; m1_read_ack = 1;
      #1;
      total++; if ({m1_read_valid, m0_read_valid} !== 2'b10) begin bad++; $display("FAIL ct_prio_rd r=%0d got=%b want=10", r, {m1_read_valid, m0_read_valid}); end
      total++; if ({rr_m1_read_valid, rr_m0_read_valid, rr_s_read_ack} !== {exp_rr, ~exp_rr, 1'b1})
        begin bad++; $display("FAIL ct_rr_rd r=%0d got=%b want_m=%0d", r, {rr_m1_read_valid, rr_m0_read_valid, rr_s_read_ack}, exp_rr); end
      rr_last = exp_rr;
    end
    @(negedge clk_i);
    clear_in();
  endtask

  task automatic test_read_m0();
    xfer(1'b0, 1'b0, 3'd3, $urandom, 4'($urandom), $urandom);
  endtask

  task automatic test_write_m1();
    xfer(1'b1, 1'b1, 3'd0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF);
  endtask

  task automatic test_drop();
    logic [31:0] d;
    @(negedge clk_i);
    clear_in();
    set_req(1'b0, 1'b1, 1'b0, 3'd0, 4'h3, 32'h0000_0A00);
    @(negedge clk_i); #1;
    total++; if ({s_req_valid, m0_req_ready} !== 2'b10) begin bad++; $display("FAIL drop_req got=%b want=10", {s_req_valid, m0_req_ready}); end
    set_req(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    set_req(1'b1, 1'b1, 1'b1, 3'd0, 4'hC, 32'h0000_0B00);
    #1;
    total++; if ({s_req_valid, m1_req_ready, busy} !== 3'b001) begin bad++; $display("FAIL drop_fall got=%b want=001", {s_req_valid, m1_req_ready, busy}); end
    @(negedge clk_i); #1;
    total++; if ({busy, s_req_valid} !== 2'b00) begin bad++; $display("FAIL drop_idle got=%b want=00", {busy, s_req_valid}); end
    @(negedge clk_i); #1;
    total++; if ({s_req_valid, s_req_we, s_req_addr} !== {2'b11, 32'h0000_0B00}) begin bad++; $display("FAIL drop_m1 got=%0b/%0b/%h want=1/1/00000b00", s_req_valid, s_req_we, s_req_addr); end
    s_req_ready = 1;
    #1;
    total++; if ({m1_req_ready, m0_req_ready} !== 2'b10) begin bad++; $display("FAIL drop_rdy got=%b want=10", {m1_req_ready, m0_req_ready}); end
    @(negedge clk_i);
    d = $urandom;
    set_req(1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    s_req_ready = 0; m1_write_valid = 1; m1_write_data = d;
    #1;
    total++; if ({s_write_valid, s_write_data} !== {1'b1, d}) begin bad++; $display("FAIL drop_wr got=%0b/%h want=1/%h", s_write_valid, s_write_data, d); end
    @(negedge clk_i);
    clear_in();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_end got=%0b want=0", busy); end
    rr_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    clear_in();
    set_req(1'b0, 1'b1, 1'b0, 3'd7, 4'hF, 32'h0000_0C00);
    s_req_ready = 1;
    @(negedge clk_i); #1;
    total++; if (s_req_valid !== 1'b1) begin bad++; $display("FAIL rm_req got=%0b want=1", s_req_valid); end
    for (int b = 1; b <= 2; b++) begin
      @(negedge clk_i);
      set_req(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
      s_req_ready = 0; s_read_valid = 1; s_read_data = $urandom; m0_read_ack = 1;
      #1;
      total++; if (m0_read_valid !== 1'b1) begin bad++; $display("FAIL rm_beat%0d got=%0b want=1", b, m0_read_valid); end
    end
    #1 rstn_i = 0;
    #1;
    total++; if ({m0_read_valid, m1_read_valid, s_read_ack, busy, rr_busy, s_req_valid} !== 6'd0)
      begin bad++; $display("FAIL rm_async got=%b want=000000", {m0_read_valid, m1_read_valid, s_read_ack, busy, rr_busy, s_req_valid}); end
    total++; if ({m0_read_data, s_req_addr} !== 64'd0) begin bad++; $display("FAIL rm_data got=%h/%h want=0/0", m0_read_data, s_req_addr); end
    @(negedge clk_i);
    rstn_i = 1; rr_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #1;
      total++; if ({s_req_valid, busy, m0_read_valid, s_read_ack} !== 4'b0000)
        begin bad++; $display("FAIL rm_after c=%0d got=%b want=0000", c, {s_req_valid, busy, m0_read_valid, s_read_ack}); end
    end
    @(negedge clk_i);
    clear_in();
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      xfer(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom, 4'($urandom), $urandom);
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_contention();
    test_read_m0();
    test_write_m1();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/req_arb.md
REQ_ARB -- requirements
Module: req_arb

Interface
REQ-001 Parameter M1_PRIO, default 1: 1 = m1 wins every contention, 0 = round-robin between m0/m1.
REQ-002 Parameter CNT_W, default 3: beat-counter width; beats per transaction = req_len+1.
REQ-003 clk_i  in  1  single system clock; all logic on rising edge.
REQ-004 rstn_i  in  1  asynchronous, active-low reset.
REQ-005 mN_req_valid  in  1  master N (N=0 CPU, N=1 VGA fetch) request valid.
REQ-006 mN_req_ready  out  1  request accepted by slave, routed to granted master only.
REQ-007 mN_req_we / mN_req_len / mN_req_mask / mN_req_addr  in  1/3/4/32  request attributes.
REQ-008 mN_write_valid / mN_write_data  in  1/32  write beat, no backpressure.
REQ-009 mN_read_valid  out  1  read beat available, routed to granted master only.
REQ-010 mN_read_data  out  32  read data, broadcast to both masters.
REQ-011 mN_read_ack  in  1  master consumes read beat.
REQ-012 s_req_valid / s_req_ready  out/in  1/1  slave (SDRAM controller) request handshake.
REQ-013 s_req_we / s_req_len / s_req_mask / s_req_addr  out  1/3/4/32  muxed from granted master.
REQ-014 s_write_valid / s_write_data  out  1/32  muxed from granted master; valid gated to 0 outside WDATA.
REQ-015 s_read_valid / s_read_data / s_read_ack  in/in/out  1/32/1  slave read channel; ack gated to 0 outside RDATA.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 State machine SHALL have states IDLE, REQ, WDATA, RDATA.
REQ-018 IDLE: when any mN_req_valid is high, register grant g and move to REQ next cycle; no output asserted toward the slave in IDLE.
REQ-019 Arbitration SHALL be: one requester -> it wins; both, M1_PRIO=1 -> m1; both, M1_PRIO=0 -> master not granted last (pointer resets to "last=m1", so m0 wins first tie).
REQ-020 REQ: s_req_valid = mg_req_valid, attributes from mg; mg_req_ready = s_req_ready; other master's ready = 0.
REQ-021 On s_req_valid & s_req_ready: latch we and len, clear beat counter, go to WDATA if we=1 else RDATA.
REQ-022 If mg_req_valid drops in REQ before acceptance, return to IDLE (grant released, pointer unchanged).
REQ-023 WDATA: each mg_write_valid cycle is one beat; the other master's write_valid is ignored.
REQ-024 RDATA: mg_read_valid = s_read_valid; s_read_ack = mg_read_ack; a beat counts when s_read_valid & s_read_ack.
REQ-025 On the beat where counter == latched len, return to IDLE next cycle; round-robin pointer updates to g at that point.
REQ-026 len=0 (single beat) and len=7 (8 beats) SHALL both complete correctly; counter SHALL NOT wrap within a transaction.
REQ-027 A new grant SHALL NOT be issued before the previous transaction's last beat; minimum gap one IDLE cycle.
REQ-028 Request latency: mN_req_valid high in cycle t with arbiter IDLE -> s_req_valid high in cycle t+1.

Reset
REQ-029 rstn_i low SHALL immediately force IDLE, counter 0, pointer "last=m1", and all outputs (ready, valid, ack, busy, s_* attributes) to 0.
REQ-030 Reset mid-transaction SHALL abandon it; no beat forwarded after reset release until a fresh request.

Structure
REQ-031 Shared package req_pkg SHALL hold the state enum, LEN_W=3, MASK_W=4, ADDR_W=32, DATA_W=32.
REQ-032 Round-robin/priority decision SHALL be one sub-module req_rr_arb (two requests, pointer, M1_PRIO in; grant out).
REQ-033 Datapath muxes SHALL be combinational from registered grant; only FSM, grant, pointer, latched we/len, counter are registered.

Verification
REQ-034 m0 read len=3 alone, slave ready at once, 4 read_valid/ack beats -> m0 gets 4 beats, busy falls after 4th, m1_read_valid stays 0.
REQ-035 m0 and m1 requesting same cycle, M1_PRIO=0, three back-to-back rounds -> grants m0, m1, m0.
REQ-036 Same contention, M1_PRIO=1 -> m1 granted every round while m1_req_valid held.
REQ-037 m1 write len=0 addr 0x40000010 mask 0xF data 0xDEADBEEF -> one s_write_valid beat with that data, IDLE next cycle.
REQ-038 rstn_i low during beat 2 of an 8-beat read -> all outputs 0 asynchronously; after release s_req_valid stays 0 until new request.
REQ-039 m0 drops req_valid in REQ with s_req_ready=0 -> IDLE next cycle; pending m1 granted the following cycle.
